ase_wrrsp_gen: RTL

//  Responder end of the CCI-P C1 write channel. Consumes AFU write/fence request headers (TxHdr_t)
//  and returns in-order RxHdr_t write and fence responses after a minimum latency.

---
 rtl/ase_wrrsp_if.sv | 31 +++
 rtl/ase_wrrsp_gen.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/ase_wrrsp_if.sv
// ============================================================================
// Module : ase_wrrsp_if
// Brief  : C1 write request / response bundle between AFU and responder
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface ase_wrrsp_if #(
  parameter int DEPTH_LOG2 = 3
) ();
  logic                  wr_valid;
  logic [79:0]           wr_hdr;
  logic                  wr_almfull;
  logic                  rsp_valid;
  logic [27:0]           rsp_hdr;
  logic [DEPTH_LOG2:0]   occupancy;
  logic                  err_proto;
  logic                  err_ovf;

  modport master (
    output wr_valid, wr_hdr,
    input  wr_almfull, rsp_valid, rsp_hdr, occupancy, err_proto, err_ovf
  );

  modport slave (
    input  wr_valid, wr_hdr,
    output wr_almfull, rsp_valid, rsp_hdr, occupancy, err_proto, err_ovf
  );
endinterface

`default_nettype wire

// File: rtl/ase_wrrsp_gen.sv
// ============================================================================
// Module : ase_wrrsp_gen
// Brief  : CCI-P C1 write/fence responder with MCL tracking and latency FIFO
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ase_wrrsp_gen #(
  parameter int         DEPTH_LOG2    = 3,
  parameter int         ALMFULL_SLACK = 2,
  parameter int         MIN_LAT       = 4,
  parameter bit         PACK_MCL      = 1'b1,
  parameter logic [1:0] VA_MAP        = 2'b01
) (
  input  logic          clk,
  input  logic          rst_n,
  ase_wrrsp_if.slave    bus
);

  localparam int                  c_depth       = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] c_full_cnt    = (DEPTH_LOG2+1)'(c_depth);
  localparam logic [DEPTH_LOG2:0] c_almfull_cnt = (DEPTH_LOG2+1)'(c_depth - ALMFULL_SLACK);
  localparam logic [8:0]          c_min_lat     = 9'(MIN_LAT);
  localparam logic [3:0]          c_rt_wrline_i = 4'd3;
  localparam logic [3:0]          c_rt_wrline_m = 4'd4;
  localparam logic [3:0]          c_rt_wrfence  = 4'd6;
  localparam logic [3:0]          c_rsp_wr      = 4'd2;
  localparam logic [3:0]          c_rsp_fence   = 4'd4;
  localparam logic [1:0]          c_vc_va       = 2'd0;
  localparam logic [0:0]          c_st_idle     = 1'b0;
  localparam logic [0:0]          c_st_inpkt    = 1'b1;

  // Request header fields
  wire [15:0] w_mdata   = bus.wr_hdr[15:0];
  wire [1:0]  w_addr_lo = bus.wr_hdr[17:16];
  wire [3:0]  w_rtype   = bus.wr_hdr[67:64];
  wire [1:0]  w_len     = bus.wr_hdr[69:68];
  wire        w_sop     = bus.wr_hdr[71];
  wire [1:0]  w_vc      = bus.wr_hdr[73:72];
  wire        w_unused_hdr = ^{bus.wr_hdr[79:74], bus.wr_hdr[70], bus.wr_hdr[63:18]};

  wire w_is_wr    = (w_rtype == c_rt_wrline_i) || (w_rtype == c_rt_wrline_m);
  wire w_is_fence = (w_rtype == c_rt_wrfence);
  wire w_misalign = ((w_len == 2'd1) && w_addr_lo[0]) || ((w_len == 2'd3) && (w_addr_lo != 2'd0));

  function automatic logic [1:0] f_vc_used(input logic [1:0] vc);
    return (vc == c_vc_va) ? VA_MAP : vc;
  endfunction

  logic [0:0]            r_state, w_state_nxt;
  logic [1:0]            r_beat, r_len, r_vc;
  logic [15:0]           r_mdata;
  logic [8:0]            r_timer;
  logic [DEPTH_LOG2-1:0] r_wr_ptr, r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic [36:0]           r_mem [c_depth];
  logic                  r_rsp_valid, r_err_proto, r_err_ovf;
  logic [27:0]           r_rsp_hdr;

  logic w_viol, w_fence, w_single, w_start, w_mid, w_done;
  logic w_push, w_push_ok, w_pop, w_full;
  logic [27:0] w_push_hdr;
  logic [3:0]  w_o_rtype;
  logic [15:0] w_o_mdata;
  logic [1:0]  w_o_clnum, w_o_vc;
  logic        w_o_fmt;

  // MCL tracker: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_st_idle;
      r_beat  <= 2'd0;
      r_len   <= 2'd0;
      r_vc    <= 2'd0;
      r_mdata <= 16'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start) begin
        r_beat  <= 2'd1;
        r_len   <= w_len;
        r_vc    <= w_vc;
        r_mdata <= w_mdata;
      end else if (w_mid && !w_done) begin
        r_beat  <= r_beat + 2'd1;
      end
    end
  end

  // MCL tracker: next-state and beat classification
  always_comb begin
    w_state_nxt = r_state;
    w_viol      = 1'b0;
    w_fence     = 1'b0;
    w_single    = 1'b0;
    w_start     = 1'b0;
    w_mid       = 1'b0;
    w_done      = 1'b0;
    if (bus.wr_valid) begin
      case (r_state)
        c_st_idle: begin
          if (w_is_fence)                                             w_fence = 1'b1;
          else if (!w_is_wr || !w_sop || (w_len == 2'd2) || w_misalign) w_viol  = 1'b1;
          else if (w_len == 2'd0)                                     w_single = 1'b1;
          else begin
            w_start     = 1'b1;
            w_state_nxt = c_st_inpkt;
          end
        end
        default: begin
          if (!w_is_wr || w_sop || (w_len != r_len)) begin
            w_viol      = 1'b1;
            w_state_nxt = c_st_idle;
          end else begin
            w_mid = 1'b1;
            if (r_beat == r_len) begin
              w_done      = 1'b1;
              w_state_nxt = c_st_idle;
            end
          end
        end
      endcase
    end
  end

  // MCL tracker: response entry generation
  always_comb begin
    w_push    = 1'b0;
    w_o_rtype = c_rsp_wr;
    w_o_mdata = r_mdata;
    w_o_clnum = 2'd0;
    w_o_vc    = r_vc;
    w_o_fmt   = 1'b0;
    if (w_fence || w_single || (!PACK_MCL && w_start)) begin
      w_push    = 1'b1;
      w_o_rtype = w_fence ? c_rsp_fence : c_rsp_wr;
      w_o_mdata = w_mdata;
      w_o_vc    = w_vc;
    end else if (!PACK_MCL && w_mid) begin
      w_push    = 1'b1;
      w_o_clnum = r_beat;
    end else if (PACK_MCL && w_done) begin
      w_push    = 1'b1;
      w_o_clnum = r_len;
      w_o_fmt   = 1'b1;
    end
    w_push_hdr = {f_vc_used(w_o_vc), 1'b0, 1'b0, w_o_fmt, 1'b0, w_o_clnum, w_o_rtype, w_o_mdata};
  end

  // Latency FIFO: head pops once its age modulo 512 reaches MIN_LAT
  wire [36:0] w_head = r_mem[r_rd_ptr];
  wire [8:0]  w_age  = r_timer - w_head[36:28];

  assign w_full    = (r_count == c_full_cnt);
  assign w_pop     = (r_count != '0) && (w_age >= c_min_lat);
  assign w_push_ok = w_push && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= {r_timer, w_push_hdr};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timer     <= 9'd0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_hdr   <= 28'd0;
      r_err_proto <= 1'b0;
      r_err_ovf   <= 1'b0;
    end else begin
      r_timer     <= r_timer + 9'd1;
      r_rsp_valid <= w_pop;
      r_rsp_hdr   <= w_pop ? w_head[27:0] : 28'd0;
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push_ok && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push_ok && w_pop) r_count <= r_count - 1'b1;
      if (w_viol)                   r_err_proto <= 1'b1;
      if (w_push && !w_push_ok)     r_err_ovf   <= 1'b1;
    end
  end

  assign bus.wr_almfull = (r_count >= c_almfull_cnt);
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_hdr    = r_rsp_hdr;
  assign bus.occupancy  = r_count;
  assign bus.err_proto  = r_err_proto;
  assign bus.err_ovf    = r_err_ovf;

endmodule

`default_nettype wire
